mole_sequencer: RTL and testbench

MOLE_SEQUENCER -- requirements
Module: mole_sequencer

---
 rtl/mole_sequencer_if.sv | 27 ++
 rtl/mole_sequencer.sv | 102 ++++++++++
 tb/tb_mole_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mole_sequencer_if.sv
// Game-side handshake between the mole sequencer and its driver: control inputs and display/score outputs.
interface mole_sequencer_if;
    logic       start;
    logic       hit;
    logic [4:0] mole_out;
    logic [7:0] score;
    logic [2:0] misses;
    logic       game_over;

    modport master (
        output start,
        output hit,
        input  mole_out,
        input  score,
        input  misses,
        input  game_over
    );

    modport slave (
        input  start,
        input  hit,
        output mole_out,
        output score,
        output misses,
        output game_over
    );
endinterface

// File: rtl/mole_sequencer.sv
// Whack-a-mole sequencer: lights one LFSR-chosen mole per window, tallies hits and misses,
// and ends the game after MAX_MISSES timeouts.
module mole_sequencer #(
    parameter int unsigned WINDOW     = 50_000_000,
    parameter int unsigned GAP        = 12_500_000,
    parameter int unsigned MAX_MISSES = 3,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    mole_sequencer_if.slave   bus
);
    localparam int unsigned MAX_CYC = (WINDOW > GAP) ? WINDOW : GAP;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SHOW, DARK, OVER} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    lfsr;
    logic [2:0]    prev_idx;
    logic [2:0]    sel_idx;
    logic [4:0]    mole_q;
    logic [7:0]    score_q;
    logic [2:0]    misses_q;
    logic          game_over_q;
    logic          lfsr_fb;

    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Next mole index: lfsr mod 5, bumped by one if it would repeat the last mole
    always_comb begin
        sel_idx = 3'(lfsr % 8'd5);
        if (sel_idx == prev_idx) begin
            sel_idx = (sel_idx == 3'd4) ? 3'd0 : sel_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lfsr        <= SEED;
            prev_idx    <= 3'd0;
            mole_q      <= 5'd0;
            score_q     <= 8'd0;
            misses_q    <= 3'd0;
            game_over_q <= 1'b0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            case (state)
                IDLE, OVER: begin
                    if (bus.start) begin
                        state       <= SHOW;
                        cnt         <= '0;
                        score_q     <= 8'd0;
                        misses_q    <= 3'd0;
                        game_over_q <= 1'b0;
                        mole_q      <= 5'b00001 << sel_idx;
                        prev_idx    <= sel_idx;
                    end
                end
                SHOW: begin
                    cnt <= cnt + CW'(1);
                    // A hit on the timeout cycle still counts as a hit
                    if (bus.hit) begin
                        score_q <= (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        mole_q  <= 5'd0;
                        cnt     <= '0;
                        state   <= DARK;
                    end else if (cnt == CW'(WINDOW - 1)) begin
                        misses_q <= misses_q + 3'd1;
                        mole_q   <= 5'd0;
                        cnt      <= '0;
                        if (misses_q + 3'd1 == 3'(MAX_MISSES)) begin
                            state       <= OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            state <= DARK;
                        end
                    end
                end
                DARK: begin
                    if (cnt == CW'(GAP - 1)) begin
                        state    <= SHOW;
                        cnt      <= '0;
                        mole_q   <= 5'b00001 << sel_idx;
                        prev_idx <= sel_idx;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mole_out  = mole_q;
    assign bus.score     = score_q;
    assign bus.misses    = misses_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_mole_sequencer.sv
// Randomized + directed bench for mole_sequencer; a game-level reference model feeds a scoreboard queue.
module tb_mole_sequencer;
    localparam int unsigned WINDOW     = 4;
    localparam int unsigned GAP        = 2;
    localparam int unsigned MAX_MISSES = 3;
    localparam logic [7:0]  SEED       = 8'hA5;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mole_sequencer_if bus ();

    mole_sequencer #(
        .WINDOW    (WINDOW),
        .GAP       (GAP),
        .MAX_MISSES(MAX_MISSES),
        .SEED      (SEED)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] mole;
        logic [7:0] score;
        logic [2:0] misses;
        logic       over;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: game phase plus cycles left in the current lit/dark period
    int         m_phase;   // 0 waiting, 1 lit, 2 dark, 3 finished
    int         m_left;
    logic [7:0] m_lfsr;
    int         m_prev;
    int         m_mole_idx;
    int         m_score;
    int         m_miss;
    bit         m_over;

    function automatic void light_new(input logic [7:0] cur);
        int idx;
        idx = int'(cur) % 5;
        if (idx == m_prev) idx = (idx + 1) % 5;
        m_prev     = idx;
        m_mole_idx = idx;
        m_phase    = 1;
        m_left     = WINDOW;
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit h);
        logic [7:0] cur;
        if (r) begin
            m_phase = 0; m_left = 0; m_lfsr = SEED; m_prev = 0;
            m_mole_idx = -1; m_score = 0; m_miss = 0; m_over = 0;
            return;
        end
        cur    = m_lfsr;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        case (m_phase)
            0, 3: if (s) begin
                m_score = 0; m_miss = 0; m_over = 0;
                light_new(cur);
            end
            1: begin
                m_left--;
                if (h) begin
                    if (m_score < 255) m_score++;
                    m_mole_idx = -1; m_phase = 2; m_left = GAP;
                end else if (m_left == 0) begin
                    m_miss++;
                    m_mole_idx = -1;
                    if (m_miss == MAX_MISSES) begin
                        m_phase = 3; m_over = 1;
                    end else begin
                        m_phase = 2; m_left = GAP;
                    end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) light_new(cur);
            end
        endcase
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.mole   = (m_mole_idx < 0) ? 5'd0 : 5'(1 << m_mole_idx);
        o.score  = 8'(m_score);
        o.misses = 3'(m_miss);
        o.over   = m_over;
        return o;
    endfunction

    // Drive one cycle of inputs and queue the response expected after the next edge
    task automatic cyc(input bit r, input bit s, input bit h);
        @(negedge clk);
        reset     = r;
        bus.start = s;
        bus.hit   = h;
        model_step(r, s, h);
        exp_q.push_back(model_obs());
    endtask

    // Monitor: outputs are presented every cycle, compare just after each edge
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{bus.mole_out, bus.score, bus.misses, bus.game_over};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got mole=%b score=%0d misses=%0d over=%b want mole=%b score=%0d misses=%0d over=%b",
                             $time, a.mole, a.score, a.misses, a.over, e.mole, e.score, e.misses, e.over);
                end
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.hit   = 1'b0;
        // Reset, then idle with stray hits that must be ignored
        repeat (2) cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 1);
        // Start; hit on the 2nd lit cycle; hold hit through dark
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        repeat (2) cyc(0, 0, 1);
        // Let three windows expire to end the game, then hammer hit in OVER
        repeat (3 * WINDOW + 2 * GAP + 1) cyc(0, 0, 0);
        repeat (6) cyc(0, 0, 1);
        // New game: hit on the timeout cycle
        cyc(0, 1, 0);
        repeat (WINDOW - 1) cyc(0, 0, 0);
        cyc(0, 0, 1);
        repeat (GAP) cyc(0, 0, 0);
        // Reach score 2 then reset mid-lit, then restart at the same offset
        cyc(0, 0, 1);
        repeat (GAP) cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 1);
        repeat (2) cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 0);
        // Saturate the score with hit held high
        cyc(0, 1, 1);
        repeat (2000) cyc(0, 0, 1);
        repeat (4) cyc(0, 0, 1);
        // Random play with occasional resets and starts
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
        end
        cyc(0, 0, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
